// File: rtl/spi_defs.sv
// Shared SPI link definitions: word width, FSM encodings and default frame timing,
// so transmitters and receivers on the same link agree.
package spi_defs;

  localparam int SPI_WORD_W    = 32;
  localparam int SPI_BIT_CNT_W = 5;
  localparam int SPI_TMR_W     = 16;

  // Default timing in i_clk cycles (i_clk = 10.64 MHz).
  localparam int SPI_CLK_DIV  = 5;
  localparam int SPI_CS_SETUP = 5;
  localparam int SPI_CS_HOLD  = 5;
  localparam int SPI_CS_GAP   = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  function automatic logic [SPI_TMR_W-1:0] to_tmr(input int cycles);
    return cycles[SPI_TMR_W-1:0];
  endfunction

endpackage

// File: rtl/spi_transmitter_32bit_if.sv
// Word handshake between upstream logic and the SPI transmitter.
interface spi_transmitter_32bit_if;

  logic [spi_defs::SPI_WORD_W-1:0] i_data;
  logic                            i_valid;
  logic                            o_ready;
  logic                            o_done;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_done
  );

endinterface

// File: rtl/spi_transmitter_32bit_timer.sv
// Loadable down-counter; tc is high on the last cycle of a loaded duration of
// load_val cycles. Loading restarts the count; it then holds at zero.
module spi_tx_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // count down after each load, parking at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/spi_transmitter_32bit.sv
// SPI Mode 3 master transmitter: one 32-bit word per CS_n frame, MSB first.
//
// state | meaning
// IDLE  | o_ready high, waiting for i_valid
// SETUP | CS_n low, MOSI = d[31], SCLK high, for CS_SETUP cycles
// SHIFT | 32 bits, each a low half then a high half of CLK_DIV cycles
// HOLD  | CS_n low, SCLK high, for CS_HOLD cycles
// GAP   | CS_n high, MOSI low, for CS_GAP cycles; o_done on exit
module spi_transmitter_32bit
  import spi_defs::*;
#(
  parameter int CLK_DIV  = SPI_CLK_DIV,
  parameter int CS_SETUP = SPI_CS_SETUP,
  parameter int CS_HOLD  = SPI_CS_HOLD,
  parameter int CS_GAP   = SPI_CS_GAP
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  spi_transmitter_32bit_if.slave  bus,
  output logic                    o_SPI_CLK,
  output logic                    o_SPI_CS_n,
  output logic                    o_SPI_MOSI
);

  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_WORD_W - 1);

  spi_state_e state, state_nxt;

  logic [SPI_WORD_W-1:0]    shift_q, shift_d;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                     high_q, high_d;
  logic                     sclk_d, cs_n_d, mosi_d, ready_d, done_d;

  logic                 tmr_load;
  logic [SPI_TMR_W-1:0] tmr_val;
  logic                 tmr_tc;

  logic accept;
  logic last_half;

  assign accept    = bus.i_valid && bus.o_ready && (state == ST_IDLE);
  assign last_half = high_q && (bit_cnt_q == LAST_BIT);

  spi_tx_timer #(.W(SPI_TMR_W)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)                state_nxt = ST_SETUP;
      ST_SETUP: if (tmr_tc)                state_nxt = ST_SHIFT;
      ST_SHIFT: if (tmr_tc && last_half)   state_nxt = ST_HOLD;
      ST_HOLD:  if (tmr_tc)                state_nxt = ST_GAP;
      ST_GAP:   if (tmr_tc)                state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // next values of the datapath and the registered pins, plus timer reloads
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    high_d    = high_q;
    sclk_d    = o_SPI_CLK;
    cs_n_d    = o_SPI_CS_n;
    mosi_d    = o_SPI_MOSI;
    ready_d   = (state_nxt == ST_IDLE);
    done_d    = (state == ST_GAP) && tmr_tc;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shift_d   = bus.i_data;
          bit_cnt_d = '0;
          high_d    = 1'b1;
          sclk_d    = 1'b1;
          cs_n_d    = 1'b0;
          mosi_d    = bus.i_data[SPI_WORD_W-1];
          tmr_load  = 1'b1;
          tmr_val   = to_tmr(CS_SETUP);
        end
      end
      ST_SETUP: begin
        // first fall: MSB is already on MOSI, so no shift here
        if (tmr_tc) begin
          sclk_d   = 1'b0;
          high_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = to_tmr(CLK_DIV);
        end
      end
      ST_SHIFT: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (!high_q) begin
            sclk_d  = 1'b1;
            high_d  = 1'b1;
            tmr_val = to_tmr(CLK_DIV);
          end else if (last_half) begin
            tmr_val = to_tmr(CS_HOLD);
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q << 1;
            mosi_d    = shift_q[SPI_WORD_W-2];
            sclk_d    = 1'b0;
            high_d    = 1'b0;
            tmr_val   = to_tmr(CLK_DIV);
          end
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          cs_n_d   = 1'b1;
          mosi_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = to_tmr(CS_GAP);
        end
      end
      default: ;
    endcase
  end

  // datapath and output pin registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      high_q      <= 1'b0;
      o_SPI_CLK   <= 1'b1;
      o_SPI_CS_n  <= 1'b1;
      o_SPI_MOSI  <= 1'b0;
      bus.o_ready <= 1'b1;
      bus.o_done  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      high_q      <= high_d;
      o_SPI_CLK   <= sclk_d;
      o_SPI_CS_n  <= cs_n_d;
      o_SPI_MOSI  <= mosi_d;
      bus.o_ready <= ready_d;
      bus.o_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_transmitter_32bit.sv
// Bench for spi_transmitter_32bit: cycle-offset reference model of the pin
// waveform, SCLK-edge receiver, table-driven frames, random frames and corner
// sequences, plus a second instance at CLK_DIV=4.
module tb_spi_transmitter_32bit;
  import spi_defs::*;

  localparam int CD          = SPI_CLK_DIV;
  localparam int SHIFT_START = 1 + SPI_CS_SETUP;
  localparam int HOLD_START  = SHIFT_START + 64 * CD;
  localparam int GAP_START   = HOLD_START + SPI_CS_HOLD;
  localparam int FRAME       = GAP_START + SPI_CS_GAP;
  localparam int FRAME4      = 1 + SPI_CS_SETUP + 64 * 4 + SPI_CS_HOLD + SPI_CS_GAP;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  logic sclk, cs_n, mosi;
  logic sclk4, cs_n4, mosi4;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  spi_transmitter_32bit_if bus ();
  spi_transmitter_32bit_if bus4 ();

  spi_transmitter_32bit dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .bus        (bus),
    .o_SPI_CLK  (sclk),
    .o_SPI_CS_n (cs_n),
    .o_SPI_MOSI (mosi)
  );

  spi_transmitter_32bit #(.CLK_DIV(4)) dut4 (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .bus        (bus4),
    .o_SPI_CLK  (sclk4),
    .o_SPI_CS_n (cs_n4),
    .o_SPI_MOSI (mosi4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: pins as a function of cycles elapsed since the accept edge.
  // Packed as {cs_n, sclk, mosi, ready, done}.
  function automatic logic [4:0] model_out(input int o, input logic [31:0] w);
    int rel, k;
    if (o == 0)          return 5'b11010;
    if (o == FRAME)      return 5'b11011;
    if (o < SHIFT_START) return {1'b0, 1'b1, w[31], 2'b00};
    if (o < HOLD_START) begin
      rel = o - SHIFT_START;
      k   = rel / (2 * CD);
      return {1'b0, (rel % (2 * CD)) >= CD, w[31 - k], 2'b00};
    end
    if (o < GAP_START)   return {1'b0, 1'b1, w[0], 2'b00};
    return 5'b11000;
  endfunction

  int          off = 0;
  logic [31:0] mword = '0;
  logic [31:0] exp_q[$];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      off = 0;
      exp_q.delete();
    end else if ((off == 0 || off == FRAME) && bus.i_valid) begin
      off   = 1;
      mword = bus.i_data;
      exp_q.push_back(bus.i_data);
    end else if (off == 0 || off == FRAME) begin
      off = 0;
    end else begin
      off = off + 1;
    end
  end

  always @(negedge i_clk)
    check("pins{cs,sclk,mosi,rdy,done}",
          32'({cs_n, sclk, mosi, bus.o_ready, bus.o_done}),
          32'(model_out(off, mword)));

  // Receiver on the main link: sample MOSI on each SCLK rise inside CS_n.
  int          rises = 0, last_rises = 0, rx_frames = 0;
  logic [31:0] rx = '0, last_rx = '0;

  always @(negedge cs_n) begin rises = 0; rx = '0; end
  always @(posedge sclk) if (!cs_n && i_rst_n) begin rises++; rx = {rx[30:0], mosi}; end
  always @(posedge cs_n) begin
    if (i_rst_n) begin
      last_rx    = rx;
      last_rises = rises;
      rx_frames++;
      if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(exp_q.size()), 32'd1);
      else                   check("rx_word_vs_accepted", rx, exp_q.pop_front());
      check("rx_sclk_rises", 32'(rises), 32'd32);
    end
  end

  int          rises4 = 0, last_rises4 = 0, frames4 = 0;
  logic [31:0] rx4 = '0, last_rx4 = '0;

  always @(negedge cs_n4) begin rises4 = 0; rx4 = '0; end
  always @(posedge sclk4) if (!cs_n4 && i_rst_n) begin rises4++; rx4 = {rx4[30:0], mosi4}; end
  always @(posedge cs_n4) if (i_rst_n) begin last_rx4 = rx4; last_rises4 = rises4; frames4++; end

  // Offer one word, then count cycles until o_done; optionally pulse i_valid
  // with different data partway through the frame.
  task automatic send_frame(input logic [31:0] d, input logic [31:0] late, input bit do_late,
                            input int late_at, output int lat);
    @(negedge i_clk);
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    bus.i_data  = $urandom;
    lat = 1;
    while (!bus.o_done && lat < FRAME + 50) begin
      if (do_late && lat == late_at) begin bus.i_data = late; bus.i_valid = 1'b1; end
      else if (do_late && lat == late_at + 1) bus.i_valid = 1'b0;
      @(negedge i_clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] late;
    bit          do_late;
    logic [31:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[4];
  int          lat, n, frames_before;
  logic [31:0] d;
  logic [31:0] words4[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hA5C3_0F81, 32'h0000_0000, 1'b0, 32'hA5C3_0F81, 341};
    vecs[1] = '{32'hA5C3_0F81, 32'h1234_5678, 1'b1, 32'hA5C3_0F81, 341};
    vecs[2] = '{32'h8000_0001, 32'h0000_0000, 1'b0, 32'h8000_0001, 341};
    vecs[3] = '{32'h7FFF_FFFE, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFE, 341};
    words4[0] = 32'h8000_0001;
    words4[1] = 32'h7FFF_FFFE;

    bus.i_data = '0;  bus.i_valid = 1'b0;
    bus4.i_data = '0; bus4.i_valid = 1'b0;
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_pins", 32'({cs_n, sclk, mosi, bus.o_ready, bus.o_done}), 32'b11010);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].late, vecs[i].do_late, 100, lat);
      check($sformatf("vec%0d_done_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_word", i), last_rx, vecs[i].exp_word);
      check($sformatf("vec%0d_rises", i), 32'(last_rises), 32'd32);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
    end

    // back-to-back: i_valid held across the frame boundary
    frames_before = rx_frames;
    @(negedge i_clk);
    bus.i_data = 32'hFFFF_FFFF; bus.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_data = 32'h0000_0000;
    n = 0;
    while (!cs_n && n < FRAME + 20) begin @(negedge i_clk); n++; end
    n = 0;
    while (cs_n && n < 50) begin @(negedge i_clk); n++; end
    bus.i_valid = 1'b0;
    // GAP cycles plus the IDLE cycle in which the next word is accepted
    check("b2b_cs_high_cycles", 32'(n), 32'(SPI_CS_GAP + 1));
    n = 0;
    while (!bus.o_done && n < FRAME + 20) begin @(negedge i_clk); n++; end
    check("b2b_second_latency", 32'(n + 1), 32'(FRAME));
    check("b2b_frames", 32'(rx_frames - frames_before), 32'd2);
    check("b2b_last_word", last_rx, 32'h0000_0000);

    // reset in the low half of bit 17
    @(negedge i_clk);
    bus.i_data = 32'h5555_AAAA; bus.i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    repeat (179) @(negedge i_clk);
    check("pre_reset_sclk_low", 32'(sclk), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_reset_pins", 32'({cs_n, sclk, mosi, bus.o_ready}), 32'b1101);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    frames_before = rx_frames;
    send_frame(32'hDEAD_BEEF, 32'h0, 1'b0, 0, lat);
    check("after_reset_latency", 32'(lat), 32'(FRAME));
    check("after_reset_word", last_rx, 32'hDEAD_BEEF);
    check("after_reset_frames", 32'(rx_frames - frames_before), 32'd1);

    for (int r = 0; r < 6; r++) begin
      d = $urandom;
      send_frame(d, $urandom, 1'($urandom_range(0, 1)), $urandom_range(2, FRAME - 2), lat);
      check("rand_latency", 32'(lat), 32'(FRAME));
      check("rand_word", last_rx, d);
      repeat ($urandom_range(0, 20)) @(negedge i_clk);
    end

    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      bus4.i_data = words4[i]; bus4.i_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      bus4.i_valid = 1'b0;
      n = 1;
      while (!bus4.o_done && n < FRAME4 + 50) begin @(negedge i_clk); n++; end
      check("div4_latency", 32'(n), 32'(FRAME4));
      check("div4_word", last_rx4, words4[i]);
      check("div4_rises", 32'(last_rises4), 32'd32);
    end
    check("div4_frames", 32'(frames4), 32'd2);

    repeat (3) @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
